lfsr_noise_arbiter: RTL and testbench
=====================================

Name: lfsr_noise_arbiter

Overview:
Shares one 15-bit Galois noise LFSR among NREQ requesters. Each request is for a single WORD_W-bit random word.
- Round-robin arbitration picks one requester.
- The LFSR is stepped WORD_W times; its output bit is collected serially into the word.
- The word is returned on a valid/ready response channel, tagged with the requester index.
- A seed-load port lets the system controller reseed the generator while the block is idle.

Parameters:
NREQ, 4, number of requesters (2..16).
WORD_W, 8, bits per returned word (1..32).
SEED, 15'h0001, LFSR value after reset (0 is replaced by 1).

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req  in  NREQ  level request per requester
seed_load  in  1  one-cycle strobe: load seed_data into the LFSR
seed_data  in  15  new seed value
rsp_valid  out  1  response word available
rsp_ready  in  1  consumer accepts response
rsp_data  out  WORD_W  random word
rsp_id  out  $clog2(NREQ)  index of the served requester
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, while rst_n=0):
  - state=IDLE, lfsr=SEED (1 if SEED==0), rr_ptr=0.
  - rsp_valid=0, rsp_data=0, rsp_id=0, busy=0.
- LFSR step:
  - If lfsr[0]=1: lfsr <= (lfsr>>1) ^ 15'h6000.
  - Otherwise: lfsr <= lfsr>>1.
  - The output bit is bit 14 of the post-step value.
- IDLE:
  - If seed_load=1: lfsr <= seed_data, or 1 if seed_data==0. Arbitration is skipped that cycle; seed load has priority.
  - Else if req!=0: the winner is the first set bit at or after rr_ptr, searching upward with wrap. Latch winner into rsp_id, clear the bit counter, go to SHIFT.
- SHIFT:
  - Each cycle: step the LFSR, then word <= {word[WORD_W-2:0], new lfsr[14]}.
  - After the WORD_W-th step, go to DELIVER.
  - Timing: req sampled high at edge 0 gives rsp_valid=1 after edge WORD_W+1.
- DELIVER:
  - rsp_valid=1 and rsp_data is held stable until rsp_valid&&rsp_ready.
  - On that edge: rsp_valid <= 0, rr_ptr <= (rsp_id+1) mod NREQ, go to IDLE.
  - IDLE always lasts at least one cycle between grants.
- req handling:
  - req is not required to stay high after the grant edge.
  - A drop during SHIFT or DELIVER does not abort; the word is still delivered.
  - A requester whose req is low at the arbitration edge loses its turn.
- seed_load outside IDLE is ignored and the LFSR is unchanged. The master must wait for busy=0.
- rst_n asserted mid-SHIFT or mid-DELIVER aborts immediately. The partial word is discarded and all registers return to reset values.
- The LFSR never holds 0; every load path enforces this.

Optional Feature:
LFSR_FREERUN_EN:
- Defined: the LFSR also steps once per cycle in IDLE and DELIVER. A seed_load in IDLE overrides that cycle's step. Returned words then depend on request timing.
- Undefined: the LFSR steps only in SHIFT, so the word sequence is fully deterministic for a given seed. All Test Plan values assume this build.

Decomposition:
Package lfsr_noise_pkg holds:
- LFSR_W=15, LFSR_TAPS=15'h6000, LFSR_OUT_BIT=14.
- The state enum {IDLE, SHIFT, DELIVER}.
- A function rr_pick(req, ptr) returning the winner index.

One sub-module, lfsr_noise_core:
- Holds the 15-bit register and implements step and load (zero-guarded).
- Outputs bit 14.
- The arbiter FSM instantiates it.

Test Plan:
- Reset, SEED=1, WORD_W=8, req=4'b0001 held -> first rsp_data=8'h80, rsp_id=0. After acceptance the second word is 8'h03; internal LFSR is 15'h00C0 after word 1 and 15'h5000 after word 2.
- req=4'b1111 held, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0. rsp_valid rises 9 cycles after each grant edge, with one IDLE cycle between transactions.
- rsp_ready=0 for 20 cycles in DELIVER -> rsp_valid and rsp_data stable, busy=1. A seed_load strobe during this window leaves the next word unchanged from the seed-1 sequence.
- In IDLE, seed_load=1 with seed_data=0 and req=4'b0010 in the same cycle -> no grant that cycle, LFSR=1. The next cycle grants id 1, and the word equals 8'h80.
- rst_n pulsed low at SHIFT bit 4 -> immediate rsp_valid=0, busy=0. After release the first word again equals 8'h80.
- With LFSR_FREERUN_EN: seed 1, 3 idle cycles, then req=4'b0001 -> LFSR=15'h1800 at the grant edge and rsp_data=8'h00. Without the macro: 8'h80.

Source files
------------

// File: rtl/lfsr_noise_pkg.sv
// Shared constants, FSM state type and round-robin pick helper for lfsr_noise_arbiter.
package lfsr_noise_pkg;
   localparam int unsigned LFSR_W = 15;
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 15'h6000;
   localparam int unsigned LFSR_OUT_BIT = 14;
   localparam int unsigned RR_MAX = 16;

   typedef enum logic [1:0] {IDLE, SHIFT, DELIVER} state_e;

   // First set bit at or after ptr, searching upward and wrapping at nreq.
   function automatic logic [3:0] rr_pick(input logic [RR_MAX-1:0] req, input logic [3:0] ptr,
                                          input int unsigned nreq);
      logic [3:0]  win;
      logic        found;
      int unsigned idx;
      win   = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < RR_MAX; i++) begin
         idx = ({28'b0, ptr} + i) % nreq;
         if (!found && (i < nreq) && req[idx[3:0]]) begin
            win   = idx[3:0];
            found = 1'b1;
         end
      end
      return win;
   endfunction
endpackage

// File: rtl/lfsr_noise_arbiter_core.sv
// 15-bit Galois LFSR register with zero-guarded load and single-step update.
module lfsr_noise_core
   import lfsr_noise_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED = 15'h0001
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              step_i,
   input  logic              load_i,
   input  logic [LFSR_W-1:0] load_data_i,
   output logic              out_bit_o
);
   localparam logic [LFSR_W-1:0] ResetVal = (SEED == '0) ? LFSR_W'(1) : SEED;

   logic [LFSR_W-1:0] lfsr_q, lfsr_d, stepped;

   always_comb begin
      stepped = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
      lfsr_d  = lfsr_q;
      if (load_i) begin
         lfsr_d = (load_data_i == '0) ? LFSR_W'(1) : load_data_i;
      end else if (step_i) begin
         lfsr_d = stepped;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) lfsr_q <= ResetVal;
      else         lfsr_q <= lfsr_d;
   end

   // The collected bit is taken from the post-step value.
   assign out_bit_o = stepped[LFSR_OUT_BIT];
endmodule

// File: rtl/lfsr_noise_arbiter.sv
// Round-robin arbiter sharing one noise LFSR; returns WORD_W-bit words tagged with requester id.
// Optional macro LFSR_FREERUN_EN: LFSR also steps every IDLE and DELIVER cycle.
module lfsr_noise_arbiter
   import lfsr_noise_pkg::*;
#(
   parameter int unsigned       NREQ   = 4,
   parameter int unsigned       WORD_W = 8,
   parameter logic [LFSR_W-1:0] SEED   = 15'h0001
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [NREQ-1:0]         req_i,
   input  logic                    seed_load_i,
   input  logic [LFSR_W-1:0]       seed_data_i,
   output logic                    rsp_valid_o,
   input  logic                    rsp_ready_i,
   output logic [WORD_W-1:0]       rsp_data_o,
   output logic [$clog2(NREQ)-1:0] rsp_id_o,
   output logic                    busy_o
);
   localparam int unsigned ID_W  = $clog2(NREQ);
   localparam int unsigned CNT_W = $clog2(WORD_W + 1);

   state_e            state_q;
   logic [ID_W-1:0]   rr_ptr_q, rsp_id_q, pick_id, rr_next;
   logic [CNT_W-1:0]  cnt_q;
   logic [WORD_W-1:0] word_q;
   logic              rsp_valid_q;
   logic              shift_step, lfsr_step, lfsr_load, lfsr_bit;

   assign shift_step = (state_q == SHIFT) && (cnt_q != CNT_W'(WORD_W));
   assign lfsr_load  = seed_load_i && (state_q == IDLE);
`ifdef LFSR_FREERUN_EN
   assign lfsr_step  = shift_step || (state_q != SHIFT);
`else
   assign lfsr_step  = shift_step;
`endif

   assign pick_id = ID_W'(rr_pick(RR_MAX'(req_i), 4'(rr_ptr_q), NREQ));
   assign rr_next = (rsp_id_q == ID_W'(NREQ - 1)) ? '0 : rsp_id_q + ID_W'(1);

   lfsr_noise_core #(
      .SEED(SEED)
   ) u_core (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .step_i     (lfsr_step),
      .load_i     (lfsr_load),
      .load_data_i(seed_data_i),
      .out_bit_o  (lfsr_bit)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         rsp_id_q    <= '0;
         rsp_valid_q <= 1'b0;
         cnt_q       <= '0;
         word_q      <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               // Seed load wins over arbitration in the same cycle.
               if (!seed_load_i && (req_i != '0)) begin
                  rsp_id_q <= pick_id;
                  cnt_q    <= '0;
                  state_q  <= SHIFT;
               end
            end
            SHIFT: begin
               if (shift_step) begin
                  word_q <= (word_q << 1) | WORD_W'(lfsr_bit);
                  cnt_q  <= cnt_q + CNT_W'(1);
               end else begin
                  rsp_valid_q <= 1'b1;
                  state_q     <= DELIVER;
               end
            end
            DELIVER: begin
               if (rsp_ready_i) begin
                  rsp_valid_q <= 1'b0;
                  rr_ptr_q    <= rr_next;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rsp_valid_o = rsp_valid_q;
   assign rsp_data_o  = word_q;
   assign rsp_id_o    = rsp_id_q;
   assign busy_o      = (state_q != IDLE);
endmodule

// File: tb/tb_lfsr_noise_arbiter.sv
// Self-checking bench for lfsr_noise_arbiter (default build, NREQ=4, WORD_W=8, SEED=1).
module tb_lfsr_noise_arbiter;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req;
   logic        seed_load;
   logic [14:0] seed_data;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [7:0]  rsp_data;
   logic [1:0]  rsp_id;
   logic        busy;

   int checks = 0;
   int fails  = 0;

   int unsigned m_lfsr;
   int unsigned m_ptr;

   lfsr_noise_arbiter #(
      .NREQ  (4),
      .WORD_W(8),
      .SEED  (15'h0001)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .req_i      (req),
      .seed_load_i(seed_load),
      .seed_data_i(seed_data),
      .rsp_valid_o(rsp_valid),
      .rsp_ready_i(rsp_ready),
      .rsp_data_o (rsp_data),
      .rsp_id_o   (rsp_id),
      .busy_o     (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got running, required finished");
      $fatal(1);
   end

   // Reference model: Galois step and serial word collection from the specification rules.
   function automatic int unsigned m_step(input int unsigned v);
      return (v % 2 == 1) ? ((v / 2) ^ 32'h6000) : (v / 2);
   endfunction

   function automatic int unsigned m_word();
      int unsigned w = 0;
      for (int k = 0; k < 8; k++) begin
         m_lfsr = m_step(m_lfsr);
         w = w * 2 + ((m_lfsr / 16384) % 2);
      end
      return w;
   endfunction

   function automatic int unsigned m_pick(input int unsigned r);
      for (int i = 0; i < 4; i++) begin
         if (((r >> ((m_ptr + i) % 4)) & 1) == 1) return (m_ptr + i) % 4;
      end
      return 0;
   endfunction

   task automatic do_reset();
      rst_n = 1'b0; req = '0; seed_load = 1'b0; seed_data = '0; rsp_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      m_lfsr = 1;
      m_ptr  = 0;
   endtask

   task automatic wait_valid(output int n, output bit timed_out);
      n = 0;
      while (!rsp_valid && n < 60) begin
         @(negedge clk);
         n++;
      end
      timed_out = !rsp_valid;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", rsp_valid); end
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (rsp_data !== 8'h00) begin fails++; $display("FAIL reset_data got %h want 00", rsp_data); end
      checks++; if (rsp_id !== 2'd0) begin fails++; $display("FAIL reset_id got %0d want 0", rsp_id); end
   endtask

   task automatic test_known_vectors();
      int n; bit to;
      int unsigned w1, w2;
      req = 4'b0001; rsp_ready = 1'b1;
      wait_valid(n, to);
      w1 = m_word();
      checks++; if (to || n != 10) begin fails++; $display("FAIL kv_latency got %0d want 10", n); end
      checks++; if (rsp_data !== 8'h80 || w1 != 32'h80) begin fails++; $display("FAIL kv_word1 got %h want 80 (model %h)", rsp_data, w1); end
      checks++; if (rsp_id !== 2'd0) begin fails++; $display("FAIL kv_id1 got %0d want 0", rsp_id); end
      @(negedge clk);
      wait_valid(n, to);
      w2 = m_word();
      checks++; if (to || n != 10) begin fails++; $display("FAIL kv_gap got %0d want 10", n); end
      checks++; if (rsp_data !== 8'h03 || w2 != 32'h03) begin fails++; $display("FAIL kv_word2 got %h want 03 (model %h)", rsp_data, w2); end
      checks++; if (m_lfsr != 32'h5000) begin fails++; $display("FAIL kv_model_lfsr got %h want 5000", m_lfsr); end
      req = '0;
      @(negedge clk);
      m_ptr = 1;
   endtask

   task automatic test_round_robin();
      int n; bit to;
      int unsigned exp_ids [5] = '{0, 1, 2, 3, 0};
      int unsigned w;
      do_reset();
      req = 4'b1111; rsp_ready = 1'b1;
      for (int t = 0; t < 5; t++) begin
         if (t > 0) @(negedge clk);
         wait_valid(n, to);
         w = m_word();
         checks++; if (to || n != 10) begin fails++; $display("FAIL rr_latency[%0d] got %0d want 10", t, n); end
         checks++; if (rsp_id !== exp_ids[t][1:0]) begin fails++; $display("FAIL rr_id[%0d] got %0d want %0d", t, rsp_id, exp_ids[t]); end
         checks++; if (rsp_data !== w[7:0]) begin fails++; $display("FAIL rr_data[%0d] got %h want %h", t, rsp_data, w[7:0]); end
         m_ptr = (exp_ids[t] + 1) % 4;
      end
      req = '0;
      @(negedge clk);
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rr_idle_busy got %b want 0", busy); end
   endtask

   task automatic test_stall();
      int n; bit to;
      int unsigned w, w_next;
      logic [7:0] held;
      bit bad;
      req = 4'b0001; rsp_ready = 1'b0;
      wait_valid(n, to);
      w = m_word();
      m_ptr = 1;
      held = rsp_data;
      checks++; if (to || rsp_data !== w[7:0]) begin fails++; $display("FAIL stall_word got %h want %h", rsp_data, w[7:0]); end
      req = '0;
      bad = 1'b0;
      for (int c = 0; c < 20; c++) begin
         seed_load = (c == 7); seed_data = 15'($urandom_range(1, 32767));
         @(negedge clk);
         if (rsp_valid !== 1'b1 || busy !== 1'b1 || rsp_data !== held) bad = 1'b1;
      end
      seed_load = 1'b0;
      checks++; if (bad) begin fails++; $display("FAIL stall_hold got v=%b b=%b d=%h want v=1 b=1 d=%h", rsp_valid, busy, rsp_data, held); end
      rsp_ready = 1'b1;
      @(negedge clk);
      req = 4'b0001;
      wait_valid(n, to);
      w_next = m_word();
      checks++; if (to || rsp_data !== w_next[7:0]) begin fails++; $display("FAIL stall_next_word got %h want %h", rsp_data, w_next[7:0]); end
      req = '0;
      @(negedge clk);
   endtask

   task automatic test_seed_load();
      int n; bit to;
      int unsigned w;
      seed_load = 1'b1; seed_data = 15'h0000; req = 4'b0010; rsp_ready = 1'b1;
      @(negedge clk);
      m_lfsr = 1;
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL seed_no_grant got busy=%b want 0", busy); end
      seed_load = 1'b0;
      wait_valid(n, to);
      w = m_word();
      checks++; if (to || rsp_id !== 2'd1) begin fails++; $display("FAIL seed_id got %0d want 1", rsp_id); end
      checks++; if (rsp_data !== 8'h80 || w != 32'h80) begin fails++; $display("FAIL seed_word got %h want 80", rsp_data); end
      m_ptr = 2;
      req = '0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_shift();
      int n; bit to;
      int unsigned w;
      req = 4'b0001; rsp_ready = 1'b1;
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0; req = '0;
      #1;
      checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL midreset_outputs got v=%b b=%b want 0 0", rsp_valid, busy); end
      @(negedge clk);
      rst_n = 1'b1;
      m_lfsr = 1; m_ptr = 0;
      @(negedge clk);
      req = 4'b0001;
      wait_valid(n, to);
      w = m_word();
      checks++; if (to || rsp_data !== 8'h80 || w != 32'h80) begin fails++; $display("FAIL midreset_word got %h want 80", rsp_data); end
      m_ptr = 1;
      req = '0;
      @(negedge clk);
   endtask

   task automatic test_random();
      int n; bit to;
      int unsigned r, w, id;
      for (int t = 0; t < 12; t++) begin
         if ($urandom_range(0, 3) == 0) begin
            seed_load = 1'b1; seed_data = 15'($urandom_range(0, 32767)); req = '0;
            m_lfsr = (seed_data == 15'd0) ? 1 : int'(seed_data);
            @(negedge clk);
            seed_load = 1'b0;
         end
         r = $urandom_range(1, 15);
         req = r[3:0]; rsp_ready = 1'b0;
         id = m_pick(r);
         wait_valid(n, to);
         w = m_word();
         checks++; if (to || n != 10) begin fails++; $display("FAIL rand_latency[%0d] got %0d want 10", t, n); end
         checks++; if (rsp_id !== id[1:0]) begin fails++; $display("FAIL rand_id[%0d] got %0d want %0d", t, rsp_id, id); end
         checks++; if (rsp_data !== w[7:0]) begin fails++; $display("FAIL rand_data[%0d] got %h want %h", t, rsp_data, w[7:0]); end
         if ($urandom_range(0, 1) == 1) req = '0;
         repeat ($urandom_range(0, 3)) @(negedge clk);
         rsp_ready = 1'b1;
         @(negedge clk);
         req = '0; rsp_ready = 1'b0;
         m_ptr = (id + 1) % 4;
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_known_vectors();
      test_round_robin();
      test_stall();
      test_seed_load();
      test_reset_mid_shift();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
